// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the int8 MAC sequencer.
package mac_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int LANES     = 8;
    localparam int IN_W      = 8;
    localparam int BUS_W     = LANES * IN_W;
    localparam int MAC_RES_W = 19;
    localparam int MAC_LAT   = 3;
endpackage

// File: rtl/mac_valid_pipe.sv
// Purpose: shadows the MAC pipeline, marking which cycles carry a real beat result.
// Latency: tap rises DEPTH edges after the fire edge.
// Backpressure: none; shifts every cycle.
module mac_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic nrst,
    input  logic fire,
    output logic tap
);
    logic [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | DEPTH'(fire);
        end
    end

    assign tap = pipe_q[DEPTH-1];
endmodule

// File: rtl/mac_dot_seq.sv
// Purpose: sequences an N-beat int8 dot-product job through the 8-lane MAC and accumulates. Optional: SATURATE_EN.
// Latency: result valid MAC_LAT edges after the last beat fire edge.
// Backpressure: beats accepted only in RUN; result held in DONE until i_res_ready.
module mac_dot_seq
    import mac_ctrl_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_cfg_beats,
    output logic                 o_busy,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BUS_W-1:0]     i_a,
    input  logic [BUS_W-1:0]     i_b,
    output logic [BUS_W-1:0]     o_mac_a,
    output logic [BUS_W-1:0]     o_mac_b,
    input  logic [MAC_RES_W-1:0] i_mac_res,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [ACC_W-1:0]     o_res,
    output logic                 o_sat
);
    state_t state_q, state_d;

    logic [LEN_W-1:0]        beats_q, issued_q, recv_q;
    logic signed [ACC_W-1:0] acc_q, acc_nx;
    logic                    fire, tap, start_ok, last_issue, last_recv;

    assign start_ok   = i_start && (i_cfg_beats != '0);
    assign fire       = i_valid && (state_q == RUN);
    assign last_issue = (issued_q == beats_q - LEN_W'(1));
    assign last_recv  = (recv_q == beats_q - LEN_W'(1));

    // Zeroed MAC inputs on non-fire cycles keep bubbles from adding anything.
    assign o_mac_a = fire ? i_a : '0;
    assign o_mac_b = fire ? i_b : '0;

    mac_valid_pipe #(.DEPTH(MAC_LAT)) u_valid_pipe (
        .clk  (i_clk),
        .nrst (i_nrst),
        .fire (fire),
        .tap  (tap)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (fire && last_issue) state_d = DRAIN;
            DRAIN:   if (tap && last_recv) state_d = DONE;
            DONE:    if (i_res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state_q != IDLE);
        o_ready     = (state_q == RUN);
        o_res_valid = (state_q == DONE);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            beats_q  <= '0;
            issued_q <= '0;
            recv_q   <= '0;
        end else if (state_q == IDLE && start_ok) begin
            beats_q  <= i_cfg_beats;
            issued_q <= '0;
            recv_q   <= '0;
        end else begin
            if (fire) issued_q <= issued_q + LEN_W'(1);
            if (tap)  recv_q   <= recv_q + LEN_W'(1);
        end
    end

`ifdef SATURATE_EN
    logic signed [ACC_W:0] sum_w;
    logic                  ovf;
    logic                  sat_q;

    // One guard bit: overflow shows as disagreement between the top two bits.
    always_comb begin
        sum_w  = (ACC_W+1)'(acc_q) + (ACC_W+1)'($signed(i_mac_res));
        ovf    = (sum_w[ACC_W] != sum_w[ACC_W-1]);
        acc_nx = sum_w[ACC_W-1:0];
        if (ovf) begin
            acc_nx = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sat_q <= 1'b0;
        end else if (state_q == IDLE && start_ok) begin
            sat_q <= 1'b0;
        end else if (tap && ovf) begin
            sat_q <= 1'b1;
        end
    end

    assign o_sat = sat_q;
`else
    always_comb begin
        acc_nx = acc_q + ACC_W'($signed(i_mac_res));
    end

    assign o_sat = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            acc_q <= '0;
        end else if (state_q == IDLE && start_ok) begin
            acc_q <= '0;
        end else if (tap) begin
            acc_q <= acc_nx;
        end
    end

    assign o_res = acc_q;
endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: a 3-stage MAC stand-in feeds results back; jobs are checked
// against table constants and a per-beat arithmetic reference for 32- and 20-bit accumulators.
module tb_mac_dot_seq;
    logic        i_clk, i_nrst, i_start, i_valid, i_res_ready;
    logic [7:0]  i_cfg_beats;
    logic [63:0] i_a, i_b;
    logic [18:0] i_mac_res;

    logic        o_busy, o_ready, o_res_valid, o_sat;
    logic [63:0] o_mac_a, o_mac_b;
    logic [31:0] o_res;

    logic        o_busy_w, o_ready_w, o_res_valid_w, o_sat_w;
    logic [63:0] o_mac_a_w, o_mac_b_w;
    logic [19:0] o_res_w;

    int checks = 0;
    int failures = 0;

    logic [63:0] ja [0:15];
    logic [63:0] jb [0:15];

    mac_dot_seq #(.LEN_W(8), .ACC_W(32)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_cfg_beats(i_cfg_beats),
        .o_busy(o_busy), .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b),
        .o_mac_a(o_mac_a), .o_mac_b(o_mac_b), .i_mac_res(i_mac_res),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res(o_res), .o_sat(o_sat)
    );

    mac_dot_seq #(.LEN_W(8), .ACC_W(20)) dut_w (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_cfg_beats(i_cfg_beats),
        .o_busy(o_busy_w), .i_valid(i_valid), .o_ready(o_ready_w), .i_a(i_a), .i_b(i_b),
        .o_mac_a(o_mac_a_w), .o_mac_b(o_mac_b_w), .i_mac_res(i_mac_res),
        .o_res_valid(o_res_valid_w), .i_res_ready(i_res_ready), .o_res(o_res_w), .o_sat(o_sat_w)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic int dot8(input logic [63:0] a, input logic [63:0] b);
        int s = 0;
        for (int l = 0; l < 8; l++) begin
            logic signed [7:0] x, y;
            x = a[l*8 +: 8];
            y = b[l*8 +: 8];
            s += int'(x) * int'(y);
        end
        return s;
    endfunction

    // Stand-in for the external MAC: three register stages from inputs to result.
    logic [18:0] m0, m1;
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            m0 <= '0; m1 <= '0; i_mac_res <= '0;
        end else begin
            m0 <= 19'(dot8(o_mac_a, o_mac_b));
            m1 <= m0;
            i_mac_res <= m1;
        end
    end

    function automatic void ref_job(input int n, input int w, output longint res, output bit sat);
        longint acc = 0;
        longint mx = (longint'(1) << (w - 1)) - 1;
        longint mn = -(longint'(1) << (w - 1));
        sat = 1'b0;
        for (int k = 0; k < n; k++) begin
            acc += dot8(ja[k], jb[k]);
`ifdef SATURATE_EN
            if (acc > mx) begin acc = mx; sat = 1'b1; end
            if (acc < mn) begin acc = mn; sat = 1'b1; end
`endif
        end
        acc = acc & ((longint'(1) << w) - 1);
        if (acc > mx) acc -= (longint'(1) << w);
        res = acc;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run_job(input int n, input int gap, input int hold, input bit st_run,
                           input bit st_acc, input longint e32, input longint e20, input bit s20);
        int cnt;
        longint held;
        @(negedge i_clk);
        i_start = 1'b1; i_cfg_beats = 8'(n);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_run", o_busy, 1);
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) begin
                i_valid = 1'b0; i_a = {$urandom, $urandom}; i_b = {$urandom, $urandom};
                #1 chk("bubble_zero", longint'(o_mac_a | o_mac_b), 0);
                @(negedge i_clk);
            end
            i_valid = 1'b1; i_a = ja[k]; i_b = jb[k];
            i_start = st_run && (k == 0);
            #1 chk("ready_run", o_ready, 1);
            chk("mac_a_pass", longint'(o_mac_a), longint'(ja[k]));
            @(negedge i_clk);
            i_valid = 1'b0; i_start = 1'b0;
        end
        chk("ready_drain", o_ready, 0);
        cnt = 0;
        while (!o_res_valid && cnt < 50) begin
            @(negedge i_clk);
            cnt++;
        end
        chk("latency", cnt, 3);
        chk("w_ctrl", {o_busy_w, o_ready_w, o_res_valid_w}, 3'b101);
        chk("w_mac_idle", longint'(o_mac_a_w | o_mac_b_w), 0);
        held = longint'($signed(o_res));
        for (int h = 0; h < hold; h++) begin
            i_start = 1'b1; i_cfg_beats = 8'd1;
            @(negedge i_clk);
            i_start = 1'b0;
            chk("hold_valid", o_res_valid, 1);
            chk("hold_stable", longint'($signed(o_res)), held);
        end
        chk("res32", longint'($signed(o_res)), e32);
        chk("sat32", o_sat, 0);
        chk("res20", longint'($signed(o_res_w)), e20);
        chk("sat20", o_sat_w, s20);
        i_res_ready = 1'b1; i_start = st_acc; i_cfg_beats = 8'd1;
        @(negedge i_clk);
        i_res_ready = 1'b0; i_start = 1'b0;
        chk("idle_after", {o_busy, o_res_valid}, 0);
    endtask

    typedef struct {
        int n; logic [63:0] a; logic [63:0] b; int gap; int hold;
        longint e32; longint e20s; longint e20w; bit s20;
    } vec_t;
    vec_t tbl [5];

    initial begin
        longint r32, r20;
        bit s32, sw;
        int n;
        tbl[0] = '{1, 64'h0101010101010101, 64'h0101010101010101, 0, 0, 8, 8, 8, 1'b0};
        tbl[1] = '{4, 64'h8080808080808080, 64'h8080808080808080, 0, 0, 524288, 524287, -524288, 1'b1};
        tbl[2] = '{3, 64'h0706050403020100, 64'hFFFFFFFFFFFFFFFF, 2, 0, -84, -84, -84, 1'b0};
        tbl[3] = '{2, 64'h7F7F7F7F7F7F7F7F, 64'h8080808080808080, 0, 5, -260096, -260096, -260096, 1'b0};
        tbl[4] = '{8, 64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F, 0, 0, 1032256, 524287, -16320, 1'b1};

        i_nrst = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_res_ready = 1'b0;
        i_cfg_beats = '0; i_a = '0; i_b = '0;
        repeat (2) @(negedge i_clk);
        chk("rst_ctrl", {o_busy, o_ready, o_res_valid, o_sat}, 0);
        chk("rst_res", longint'(o_res), 0);
        i_nrst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin ja[k] = tbl[i].a; jb[k] = tbl[i].b; end
`ifdef SATURATE_EN
            run_job(tbl[i].n, tbl[i].gap, tbl[i].hold, i == 3, i == 3, tbl[i].e32, tbl[i].e20s, tbl[i].s20);
`else
            run_job(tbl[i].n, tbl[i].gap, tbl[i].hold, i == 3, i == 3, tbl[i].e32, tbl[i].e20w, 1'b0);
`endif
        end

        // Abort mid-RUN, then a fresh single-beat job.
        @(negedge i_clk);
        i_start = 1'b1; i_cfg_beats = 8'd3;
        @(negedge i_clk);
        i_start = 1'b0; i_valid = 1'b1; i_a = 64'h0303030303030303; i_b = i_a;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_nrst = 1'b0;
        #1 chk("abort_ctrl", {o_busy, o_ready, o_res_valid, o_sat}, 0);
        chk("abort_res", longint'(o_res), 0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        ja[0] = 64'h0101010101010101; jb[0] = ja[0];
        run_job(1, 0, 0, 1'b0, 1'b0, 8, 8, 1'b0);

        @(negedge i_clk);
        i_start = 1'b1; i_cfg_beats = 8'd0;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("zero_beats_idle", {o_busy, o_ready}, 0);

        for (int j = 0; j < 20; j++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                ja[k] = {$urandom, $urandom};
                jb[k] = {$urandom, $urandom};
            end
            ref_job(n, 32, r32, s32);
            ref_job(n, 20, r20, sw);
            run_job(n, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), r32, r20, sw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
